// File: rtl/axis_sink_pkg.sv
// Shared constants, FSM state type and keep-mask helpers for the AXI4-Stream sink monitor.
package axis_sink_pkg;

    localparam int ERR_KEEP_HOLE = 0;
    localparam int ERR_STRB      = 1;
    localparam int ERR_OVERLONG  = 2;

    // Widest keep mask supported (1024-bit TDATA).
    localparam int KEEP_MAX = 128;

    typedef enum logic {IDLE, IN_PKT} pkt_state_e;

    function automatic logic [7:0] popcount(input logic [KEEP_MAX-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < KEEP_MAX; i++) n = n + 8'(v[i]);
        return n;
    endfunction

    // True only for 2^k-1 with k>=1: nonzero with no set bit above a clear one.
    function automatic logic keep_contig(input logic [KEEP_MAX-1:0] v);
        return (v != '0) && ((v & (v + KEEP_MAX'(1))) == '0);
    endfunction

endpackage

// File: rtl/axis_sink_sat_cnt.sv
// Saturating accumulator: adds add_val when add_en, sticks at all ones, clr has priority.
module axis_sink_sat_cnt #(
    parameter int CNT_W = 32,
    parameter int ADD_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add_en,
    input  logic [ADD_W-1:0] add_val,
    output logic [CNT_W-1:0] cnt
);

    localparam int SW = ((CNT_W > ADD_W) ? CNT_W : ADD_W) + 1;

    logic [SW-1:0] sum;
    logic          sat;

    assign sum = SW'(cnt) + SW'(add_val);
    assign sat = (sum > SW'({CNT_W{1'b1}}));

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (add_en)
            cnt <= sat ? '1 : sum[CNT_W-1:0];
    end

endmodule

// File: rtl/axis_sink_monitor.sv
// AXI4-Stream sink: accepts and discards beats, counts beats/packets/bytes, flags framing errors.
// Optional XOR checksum of kept TDATA bytes is built when AXIS_SINK_CHECKSUM_EN is defined.
module axis_sink_monitor
    import axis_sink_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int CNT_W         = 32,
    parameter int MAX_PKT_BEATS = 4096
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               enable,
    input  logic               clear,
    input  logic [3:0]         stall_every,
    input  logic [WIDTH-1:0]   S_AXIS_TDATA,
    input  logic               S_AXIS_TVALID,
    output logic               S_AXIS_TREADY,
    input  logic               S_AXIS_TLAST,
    input  logic [WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic [WIDTH/8-1:0] S_AXIS_TSTRB,
    output logic [CNT_W-1:0]   beat_count,
    output logic [CNT_W-1:0]   pkt_count,
    output logic [CNT_W-1:0]   byte_count,
    output logic               in_packet,
    output logic [2:0]         err_sticky
`ifdef AXIS_SINK_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0]   checksum
`endif
);

    localparam int KW    = WIDTH / 8;
    localparam int IDX_W = $clog2(MAX_PKT_BEATS) + 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_PKT_BEATS);

    logic                accept;
    logic [3:0]          stall_cnt;
    logic                stall_slot;
    pkt_state_e          state, state_nxt;
    logic [IDX_W-1:0]    beat_idx, beat_idx_nxt;
    logic [2:0]          err_set;
    logic [KEEP_MAX-1:0] keep_ext;

    assign accept   = S_AXIS_TVALID && S_AXIS_TREADY;
    assign keep_ext = KEEP_MAX'(S_AXIS_TKEEP);

    // Ready never looks at TVALID; it is a pure function of enable and the stall cadence.
    assign stall_slot = enable && (stall_every != 4'd0) && (stall_cnt == stall_every);

    always_ff @(posedge aclk) begin
        if (areset) begin
            S_AXIS_TREADY <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            S_AXIS_TREADY <= enable && !stall_slot;
            if (!enable || stall_slot)
                stall_cnt <= '0;
            else
                stall_cnt <= stall_cnt + 4'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= IDLE;
            beat_idx <= '0;
        end else begin
            state    <= state_nxt;
            beat_idx <= beat_idx_nxt;
        end
    end

    // Index saturates at the limit so an overlong packet cannot wrap back to legal.
    always_comb begin
        state_nxt    = state;
        beat_idx_nxt = beat_idx;
        if (accept) begin
            if (S_AXIS_TLAST) begin
                state_nxt    = IDLE;
                beat_idx_nxt = '0;
            end else begin
                state_nxt = IN_PKT;
                if (beat_idx != IDX_MAX)
                    beat_idx_nxt = beat_idx + IDX_W'(1);
            end
        end
    end

    assign in_packet = (state == IN_PKT);

    always_comb begin
        err_set = '0;
        if (accept) begin
            err_set[ERR_KEEP_HOLE] = S_AXIS_TLAST ? !keep_contig(keep_ext)
                                                  : (S_AXIS_TKEEP != {KW{1'b1}});
            err_set[ERR_STRB]      = |(S_AXIS_TSTRB & ~S_AXIS_TKEEP);
            err_set[ERR_OVERLONG]  = !S_AXIS_TLAST && (beat_idx >= IDX_MAX - IDX_W'(1));
        end
    end

    always_ff @(posedge aclk) begin
        if (areset || clear)
            err_sticky <= '0;
        else
            err_sticky <= err_sticky | err_set;
    end

    axis_sink_sat_cnt #(.CNT_W(CNT_W), .ADD_W(1)) u_beat_cnt (
        .clk(aclk), .rst(areset), .clr(clear),
        .add_en(accept), .add_val(1'b1), .cnt(beat_count)
    );

    axis_sink_sat_cnt #(.CNT_W(CNT_W), .ADD_W(1)) u_pkt_cnt (
        .clk(aclk), .rst(areset), .clr(clear),
        .add_en(accept && S_AXIS_TLAST), .add_val(1'b1), .cnt(pkt_count)
    );

    axis_sink_sat_cnt #(.CNT_W(CNT_W), .ADD_W(8)) u_byte_cnt (
        .clk(aclk), .rst(areset), .clr(clear),
        .add_en(accept), .add_val(popcount(keep_ext)), .cnt(byte_count)
    );

`ifdef AXIS_SINK_CHECKSUM_EN
    logic [WIDTH-1:0] data_masked;

    always_comb begin
        data_masked = '0;
        for (int i = 0; i < KW; i++)
            data_masked[8*i +: 8] = S_AXIS_TKEEP[i] ? S_AXIS_TDATA[8*i +: 8] : 8'h00;
    end

    always_ff @(posedge aclk) begin
        if (areset || clear)
            checksum <= '0;
        else if (accept)
            checksum <= checksum ^ data_masked;
    end
`else
    logic unused_tdata;
    assign unused_tdata = ^S_AXIS_TDATA;
`endif

endmodule

// File: tb/tb_axis_sink_monitor.sv
// Bench for axis_sink_monitor: per-cycle scoreboard of counters/status plus per-scenario checks.
module tb_axis_sink_monitor;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  stall_every = 4'd0;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic [3:0]  tkeep = '0;
    logic [3:0]  tstrb = '0;

    logic        tready;
    logic [31:0] beat_count, pkt_count, byte_count;
    logic        in_packet;
    logic [2:0]  err_sticky;

    logic        unused_rdy2, unused_inp2;
    logic [2:0]  unused_err2;
    logic [3:0]  beat2, pkt2, byte2;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] beat;
        logic [31:0] pkt;
        logic [31:0] bytes;
        logic [2:0]  err;
        logic        inpkt;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb_x;
    int unsigned m_beat, m_pkt, m_byte, m_idx;
    logic [2:0]  m_err, m_e;
    logic        m_inpkt, m_acc;

    always #5 clk = ~clk;

    axis_sink_monitor #(.WIDTH(32), .CNT_W(32), .MAX_PKT_BEATS(MAXB)) u_dut (
        .aclk(clk), .areset(areset), .enable(enable), .clear(clear),
        .stall_every(stall_every), .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid),
        .S_AXIS_TREADY(tready), .S_AXIS_TLAST(tlast), .S_AXIS_TKEEP(tkeep),
        .S_AXIS_TSTRB(tstrb), .beat_count(beat_count), .pkt_count(pkt_count),
        .byte_count(byte_count), .in_packet(in_packet), .err_sticky(err_sticky)
    );

    // Narrow-counter twin sharing every input, used to observe saturation.
    axis_sink_monitor #(.WIDTH(32), .CNT_W(4), .MAX_PKT_BEATS(4096)) u_dut_sat (
        .aclk(clk), .areset(areset), .enable(enable), .clear(clear),
        .stall_every(stall_every), .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid),
        .S_AXIS_TREADY(unused_rdy2), .S_AXIS_TLAST(tlast), .S_AXIS_TKEEP(tkeep),
        .S_AXIS_TSTRB(tstrb), .beat_count(beat2), .pkt_count(pkt2),
        .byte_count(byte2), .in_packet(unused_inp2), .err_sticky(unused_err2)
    );

    function automatic logic [3:0] sat4(input logic [31:0] v);
        return (v > 32'd15) ? 4'hF : v[3:0];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear;
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Offer one beat (called at posedge+1); returns after the accepting edge.
    task automatic send(input logic last, input logic [3:0] keep, input logic [3:0] strb,
                        output int waits);
        bit got;
        got = 1'b0;
        waits = 0;
        tvalid = 1'b1; tlast = last; tkeep = keep; tstrb = strb; tdata = $urandom;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tready === 1'b1) begin
                got = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            waits++;
            @(posedge clk);
            #1;
        end
        tvalid = 1'b0; tlast = 1'b0;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL send_timeout got no TREADY in 20 cycles, want accept");
        end
    endtask

    task automatic test_reset;
        areset = 1'b1; enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (tready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", tready); end
        vectors++;
        if (beat_count !== 0 || pkt_count !== 0 || byte_count !== 0) begin
            miscompares++; $display("FAIL reset_counts got %0d/%0d/%0d want 0/0/0", beat_count, pkt_count, byte_count);
        end
        vectors++;
        if (err_sticky !== 3'b000 || in_packet !== 1'b0) begin
            miscompares++; $display("FAIL reset_status got err=%b inpkt=%b want 000/0", err_sticky, in_packet);
        end
        step();
        areset = 1'b0;
        step();
        @(negedge clk);
        vectors++;
        if (tready !== 1'b0) begin miscompares++; $display("FAIL ready_no_enable got %b want 0", tready); end
        step();
    endtask

    task automatic test_basic;
        int w, tot;
        tot = 0;
        enable = 1'b1; stall_every = 4'd0;
        @(negedge clk);
        vectors++;
        if (tready !== 1'b0) begin miscompares++; $display("FAIL ready_latency got %b want 0", tready); end
        @(negedge clk);
        vectors++;
        if (tready !== 1'b1) begin miscompares++; $display("FAIL ready_first got %b want 1", tready); end
        step();
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < 4; b++) begin
                send(b == 3, 4'hF, 4'hF, w);
                tot += w;
            end
        @(negedge clk);
        vectors++;
        if (tot !== 0) begin miscompares++; $display("FAIL basic_stalls got %0d want 0", tot); end
        vectors++;
        if (beat_count !== 12 || pkt_count !== 3 || byte_count !== 48) begin
            miscompares++; $display("FAIL basic_counts got %0d/%0d/%0d want 12/3/48", beat_count, pkt_count, byte_count);
        end
        vectors++;
        if (err_sticky !== 3'b000) begin miscompares++; $display("FAIL basic_err got %b want 000", err_sticky); end
        step();
    endtask

    task automatic test_stall;
        enable = 1'b0;
        pulse_clear();
        step();
        enable = 1'b1; stall_every = 4'd3;
        tvalid = 1'b1; tlast = 1'b1; tkeep = 4'hF; tstrb = 4'hF; tdata = $urandom;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (tready !== ((k % 4) != 0)) begin
                miscompares++; $display("FAIL stall_pattern cycle %0d got %b want %b", k, tready, (k % 4) != 0);
            end
        end
        tvalid = 1'b0;
        stall_every = 4'd0;
        step();
        @(negedge clk);
        vectors++;
        if (beat_count !== 30 || pkt_count !== 30 || byte_count !== 120) begin
            miscompares++; $display("FAIL stall_counts got %0d/%0d/%0d want 30/30/120", beat_count, pkt_count, byte_count);
        end
        step();
    endtask

    task automatic test_keep;
        int w;
        pulse_clear();
        send(1'b0, 4'hF, 4'hF, w);
        send(1'b1, 4'h3, 4'h3, w);
        @(negedge clk);
        vectors++;
        if (byte_count !== 6 || err_sticky !== 3'b000) begin
            miscompares++; $display("FAIL keep_tail got byte=%0d err=%b want 6/000", byte_count, err_sticky);
        end
        step();
        send(1'b0, 4'h7, 4'h7, w);
        @(negedge clk);
        vectors++;
        if (err_sticky !== 3'b001) begin miscompares++; $display("FAIL keep_mid_hole got %b want 001", err_sticky); end
        step();
        send(1'b1, 4'hF, 4'hF, w);
        pulse_clear();
        send(1'b1, 4'h5, 4'h5, w);
        @(negedge clk);
        vectors++;
        if (err_sticky !== 3'b001) begin miscompares++; $display("FAIL keep_last_hole got %b want 001", err_sticky); end
        step();
        pulse_clear();
        send(1'b1, 4'h0, 4'h0, w);
        @(negedge clk);
        vectors++;
        if (err_sticky !== 3'b001 || byte_count !== 0 || pkt_count !== 1) begin
            miscompares++; $display("FAIL keep_zero got err=%b byte=%0d pkt=%0d want 001/0/1", err_sticky, byte_count, pkt_count);
        end
        step();
    endtask

    task automatic test_strb;
        int w;
        pulse_clear();
        send(1'b1, 4'h3, 4'hF, w);
        @(negedge clk);
        vectors++;
        if (err_sticky !== 3'b010 || byte_count !== 2) begin
            miscompares++; $display("FAIL strb_outside got err=%b byte=%0d want 010/2", err_sticky, byte_count);
        end
        step();
    endtask

    task automatic test_overlong;
        int w;
        pulse_clear();
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 4'hF, 4'hF, w);
            if (i == 2) begin
                @(negedge clk);
                vectors++;
                if (err_sticky !== 3'b000) begin miscompares++; $display("FAIL ovl_early got %b want 000", err_sticky); end
                step();
            end
            if (i == 3) begin
                @(negedge clk);
                vectors++;
                if (err_sticky !== 3'b100 || in_packet !== 1'b1) begin
                    miscompares++; $display("FAIL ovl_flag got err=%b inpkt=%b want 100/1", err_sticky, in_packet);
                end
                step();
            end
        end
        @(negedge clk);
        vectors++;
        if (in_packet !== 1'b1 || pkt_count !== 0) begin
            miscompares++; $display("FAIL ovl_hold got inpkt=%b pkt=%0d want 1/0", in_packet, pkt_count);
        end
        step();
        send(1'b1, 4'hF, 4'hF, w);
        @(negedge clk);
        vectors++;
        if (in_packet !== 1'b0 || pkt_count !== 1 || beat_count !== 7 || err_sticky !== 3'b100) begin
            miscompares++; $display("FAIL ovl_end got inpkt=%b pkt=%0d beat=%0d err=%b want 0/1/7/100",
                                    in_packet, pkt_count, beat_count, err_sticky);
        end
        step();
    endtask

    task automatic test_reset_mid;
        int w;
        send(1'b0, 4'hF, 4'hF, w);
        send(1'b0, 4'hF, 4'hF, w);
        areset = 1'b1; tvalid = 1'b1; tlast = 1'b0; tkeep = 4'hF; tstrb = 4'hF;
        step();
        areset = 1'b0; tvalid = 1'b0;
        @(negedge clk);
        vectors++;
        if (tready !== 1'b0 || in_packet !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_state got rdy=%b inpkt=%b want 0/0", tready, in_packet);
        end
        vectors++;
        if (beat_count !== 0 || pkt_count !== 0 || byte_count !== 0 || err_sticky !== 3'b000) begin
            miscompares++; $display("FAIL rstmid_counts got %0d/%0d/%0d err=%b want 0/0/0/000",
                                    beat_count, pkt_count, byte_count, err_sticky);
        end
        step();
        for (int i = 0; i < 3; i++) send(1'b0, 4'hF, 4'hF, w);
        @(negedge clk);
        vectors++;
        if (err_sticky !== 3'b000 || in_packet !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_fresh got err=%b inpkt=%b want 000/1", err_sticky, in_packet);
        end
        step();
        send(1'b1, 4'hF, 4'hF, w);
        @(negedge clk);
        vectors++;
        if (pkt_count !== 1 || beat_count !== 4 || in_packet !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_end got pkt=%0d beat=%0d inpkt=%b want 1/4/0", pkt_count, beat_count, in_packet);
        end
        step();
    endtask

    task automatic test_clear_beat;
        int w;
        clear = 1'b1;
        send(1'b0, 4'hF, 4'hF, w);
        clear = 1'b0;
        @(negedge clk);
        vectors++;
        if (beat_count !== 0 || pkt_count !== 0 || byte_count !== 0 || in_packet !== 1'b1) begin
            miscompares++; $display("FAIL clr_beat got %0d/%0d/%0d inpkt=%b want 0/0/0/1",
                                    beat_count, pkt_count, byte_count, in_packet);
        end
        step();
        send(1'b1, 4'hF, 4'hF, w);
        @(negedge clk);
        vectors++;
        if (beat_count !== 1 || pkt_count !== 1 || byte_count !== 4 || in_packet !== 1'b0) begin
            miscompares++; $display("FAIL clr_after got %0d/%0d/%0d inpkt=%b want 1/1/4/0",
                                    beat_count, pkt_count, byte_count, in_packet);
        end
        step();
    endtask

    task automatic test_saturate;
        int w;
        pulse_clear();
        for (int i = 0; i < 17; i++) send(1'b1, 4'hF, 4'hF, w);
        @(negedge clk);
        vectors++;
        if (beat2 !== 4'hF || pkt2 !== 4'hF || byte2 !== 4'hF || beat_count !== 17) begin
            miscompares++; $display("FAIL sat_hold got %0d/%0d/%0d wide=%0d want 15/15/15/17",
                                    beat2, pkt2, byte2, beat_count);
        end
        step();
    endtask

    initial begin
        fork
            // Reference model: predicts post-edge state from pre-edge inputs.
            forever begin
                @(posedge clk);
                m_acc = tvalid && (tready === 1'b1);
                if (areset) begin
                    m_beat = 0; m_pkt = 0; m_byte = 0; m_idx = 0; m_err = '0; m_inpkt = 1'b0;
                end else begin
                    m_e = '0;
                    if (m_acc) begin
                        if (tlast) m_e[0] = !(tkeep inside {4'h1, 4'h3, 4'h7, 4'hF});
                        else       m_e[0] = (tkeep != 4'hF);
                        m_e[1] = ((tstrb & ~tkeep) != 4'h0);
                        m_e[2] = !tlast && (m_idx + 1 >= MAXB);
                        if (tlast) begin
                            m_idx = 0; m_inpkt = 1'b0;
                        end else begin
                            m_inpkt = 1'b1;
                            if (m_idx < MAXB) m_idx++;
                        end
                    end
                    if (clear) begin
                        m_beat = 0; m_pkt = 0; m_byte = 0; m_err = '0;
                    end else if (m_acc) begin
                        m_beat++;
                        if (tlast) m_pkt++;
                        m_byte += $countones(tkeep);
                        m_err |= m_e;
                    end
                end
                sb_q.push_back('{m_beat, m_pkt, m_byte, m_err, m_inpkt});
            end
            forever begin
                @(negedge clk);
                if (sb_q.size() > 0) begin
                    sb_x = sb_q.pop_front();
                    vectors++;
                    if (beat_count !== sb_x.beat || pkt_count !== sb_x.pkt || byte_count !== sb_x.bytes ||
                        err_sticky !== sb_x.err || in_packet !== sb_x.inpkt) begin
                        miscompares++;
                        $display("FAIL sb_state t=%0t got %0d/%0d/%0d err=%b inpkt=%b want %0d/%0d/%0d err=%b inpkt=%b",
                                 $time, beat_count, pkt_count, byte_count, err_sticky, in_packet,
                                 sb_x.beat, sb_x.pkt, sb_x.bytes, sb_x.err, sb_x.inpkt);
                    end
                    vectors++;
                    if (beat2 !== sat4(sb_x.beat) || pkt2 !== sat4(sb_x.pkt) || byte2 !== sat4(sb_x.bytes)) begin
                        miscompares++;
                        $display("FAIL sb_sat t=%0t got %0d/%0d/%0d want %0d/%0d/%0d", $time,
                                 beat2, pkt2, byte2, sat4(sb_x.beat), sat4(sb_x.pkt), sat4(sb_x.bytes));
                    end
                end
            end
        join_none

        test_reset();
        test_basic();
        test_stall();
        test_keep();
        test_strb();
        test_overlong();
        test_reset_mid();
        test_clear_beat();
        test_saturate();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
